a2d_rr_sched: RTL
=================

Name: a2d_rr_sched

Overview:
- Round-robin conversion scheduler for the external 4-channel A2D used by the Segway datapath.
- On each `nxt` request, runs one two-transaction SPI conversion for the current channel through the existing SPI master handshake (`wrt`/`done`).
- Stores the 12-bit result in that channel's holding register, then advances to the next channel.
- The holding registers drive `lft_ld`/`rght_ld` into the steering-enable logic, `steer_pot` into the steering path and `batt` into battery monitoring.

Parameters:
- CH_LFT, 3'd0, A2D channel number for the left load cell
- CH_RGHT, 3'd4, A2D channel number for the right load cell
- CH_STEER, 3'd5, A2D channel number for the steering potentiometer
- CH_BATT, 3'd6, A2D channel number for the battery divider
- GAP_CYC, 2, idle clk cycles between the two SPI transactions (>=1), so SS_n deasserts between frames

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- nxt  input  1  start conversion of current round-robin channel; sampled only in IDLE
- done  input  1  SPI master transaction-complete pulse
- rd_data  input  16  SPI master receive word; result in [11:0]
- wrt  output  1  one-cycle start pulse to SPI master (registered)
- wt_data  output  16  SPI command word (registered)
- lft_ld  output  12  latest left load conversion
- rght_ld  output  12  latest right load conversion
- steer_pot  output  12  latest steering pot conversion
- batt  output  12  latest battery conversion
- cnv_cmplt  output  1  one-cycle pulse: a holding register was updated
- busy  output  1  high in every state except IDLE

Behaviour:
- Reset values:
  - wrt=0, wt_data=16'h0000
  - all four holding registers = 12'h000
  - cnv_cmplt=0, busy=0
  - rr pointer = 0 (LFT), state = IDLE
- Round-robin order: LFT(0) -> RGHT(1) -> STEER(2) -> BATT(3) -> LFT.
  - 2-bit pointer wraps 3->0.
  - Pointer advances only on a completed conversion.
- Command word: {2'b00, ch[2:0], 11'h000}, where ch is the parameter selected by the pointer. The same word is used for both transactions.
- States:
  - IDLE: on nxt=1 -> CMD.
  - CMD: wrt=1 for exactly one cycle, wt_data loaded with the command word -> WAIT1. The first wrt is high the cycle after nxt is sampled.
  - WAIT1: wait for done=1. rd_data is ignored (response to the channel-select frame) -> GAP, gap counter cleared.
  - GAP: count GAP_CYC cycles; on the terminal count -> RD.
  - RD: wrt=1 for one cycle, wt_data unchanged -> WAIT2.
  - WAIT2: on done=1:
    - rd_data[11:0] is loaded into the holding register selected by the pointer, on that same clk edge;
    - the pointer increments;
    - -> DONE.
  - DONE: cnv_cmplt=1 for one cycle. The updated register is already visible in this cycle -> IDLE.
- Timing:
  - Minimum cycle count nxt->cnv_cmplt = 4 + GAP_CYC + (SPI latency x 2).
  - nxt may be re-asserted in the cycle after DONE.
- Boundary conditions:
  - nxt while busy=1: ignored, not queued.
  - done in IDLE, CMD, GAP, RD or DONE: ignored; no state change, no register update.
  - done and nxt high together in IDLE: nxt is honoured, done is ignored.
  - rd_data[15:12] is discarded. No sign extension; results are unsigned 0..4095.
  - Only the selected holding register changes. The other three hold their values.
  - rst_n asserted mid-conversion (any state): immediate return to reset values.
    - Pointer returns to LFT.
    - Holding registers clear.
    - A pending SPI done after reset release is ignored, because the block is in IDLE.
  - wrt never asserts for two consecutive cycles.

Decomposition:
- Shared package `segway_pkg`:
  - typedef enum for scheduler states (IDLE, CMD, WAIT1, GAP, RD, WAIT2, DONE);
  - typedef enum for the rr channel index (LFT, RGHT, STEER, BATT);
  - localparam A2D_CMD_PAD = 11'h000.
- One sub-module: `a2d_sched_sm`, the pure state machine. It takes done, nxt and gap_tc and produces wrt, ld_result, cnv_cmplt and clr_gap.
- The top level holds the pointer, gap counter, command mux and holding registers.

Test Plan:
- Reset then idle, no nxt for 100 cycles -> wrt never asserts; all outputs 0; busy=0.
- Single conversion with SPI model (done 40 cycles after each wrt):
  - pulse nxt;
  - first wt_data=16'h0000;
  - second wrt at least GAP_CYC idle cycles after the first done;
  - rd_data=16'hFABC at the second done -> lft_ld=12'hABC, cnv_cmplt one cycle, others remain 0.
- Four consecutive nxt:
  - wt_data sequence 16'h0000, 16'h2000, 16'h2800, 16'h3000;
  - results 12'h111/222/333/444 land in lft/rght/steer/batt respectively;
  - fifth nxt again targets CH_LFT.
- nxt pulsed during WAIT1, and a spurious done injected during GAP -> no extra wrt; exactly one cnv_cmplt; result is from the legitimate second done.
- rst_n low during WAIT2 (after lft_ld previously = 12'h5A5) -> lft_ld=0, pointer=LFT, wrt=0.
  - Stale done one cycle after release causes no update.
  - Next nxt sends 16'h0000.

Source files
------------

// File: rtl/segway_pkg.sv
// rtl/segway_pkg.sv - shared types and helpers for the Segway A2D scheduler
package segway_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_WAIT1,
        S_GAP,
        S_RD,
        S_WAIT2,
        S_DONE
    } sched_state_t;

    typedef enum logic [1:0] {
        RR_LFT,
        RR_RGHT,
        RR_STEER,
        RR_BATT
    } rr_ch_t;

    localparam logic [10:0] A2D_CMD_PAD = 11'h000;

    // Channel-select command: channel number in [13:11], everything else zero.
    function automatic logic [15:0] a2d_cmd_word(input logic [2:0] ch);
        return {2'b00, ch, A2D_CMD_PAD};
    endfunction

    // Round-robin successor, wrapping BATT back to LFT.
    function automatic rr_ch_t rr_next(input rr_ch_t ch);
        rr_ch_t nxt_ch;
        case (ch)
            RR_LFT:   nxt_ch = RR_RGHT;
            RR_RGHT:  nxt_ch = RR_STEER;
            RR_STEER: nxt_ch = RR_BATT;
            default:  nxt_ch = RR_LFT;
        endcase
        return nxt_ch;
    endfunction

endpackage

// File: rtl/a2d_sched_sm.sv
// rtl/a2d_sched_sm.sv - conversion sequencing state machine for the A2D scheduler
module a2d_sched_sm
    import segway_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_nxt,
    input  logic i_done,
    input  logic i_gap_tc,
    output logic o_wrt,
    output logic o_ld_cmd,
    output logic o_ld_result,
    output logic o_cnv_cmplt,
    output logic o_clr_gap,
    output logic o_gap_en,
    output logic o_busy
);

    sched_state_t r_state;
    sched_state_t w_nxt_state;
    logic         r_wrt;
    logic         r_cnv_cmplt;

    // State register; wrt and cnv_cmplt are flopped from the next state so they
    // are glitch-free and line up exactly with the CMD/RD and DONE states.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_wrt       <= 1'b0;
            r_cnv_cmplt <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_wrt       <= (w_nxt_state == S_CMD) || (w_nxt_state == S_RD);
            r_cnv_cmplt <= (w_nxt_state == S_DONE);
        end
    end

    // Next-state and per-transition strobes; done is only honoured in the WAIT states.
    always_comb begin
        w_nxt_state = r_state;
        o_ld_cmd    = 1'b0;
        o_ld_result = 1'b0;
        o_clr_gap   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_nxt) begin
                    w_nxt_state = S_CMD;
                    o_ld_cmd    = 1'b1;
                end
            end
            S_CMD: begin
                w_nxt_state = S_WAIT1;
            end
            S_WAIT1: begin
                if (i_done) begin
                    w_nxt_state = S_GAP;
                    o_clr_gap   = 1'b1;
                end
            end
            S_GAP: begin
                if (i_gap_tc) begin
                    w_nxt_state = S_RD;
                end
            end
            S_RD: begin
                w_nxt_state = S_WAIT2;
            end
            S_WAIT2: begin
                if (i_done) begin
                    w_nxt_state = S_DONE;
                    o_ld_result = 1'b1;
                end
            end
            S_DONE: begin
                w_nxt_state = S_IDLE;
            end
            default: begin
                w_nxt_state = S_IDLE;
            end
        endcase
    end

    assign o_wrt       = r_wrt;
    assign o_cnv_cmplt = r_cnv_cmplt;
    assign o_gap_en    = (r_state == S_GAP);
    assign o_busy      = (r_state != S_IDLE);

endmodule

// File: rtl/a2d_rr_sched.sv
// rtl/a2d_rr_sched.sv - round-robin A2D conversion scheduler with holding registers
module a2d_rr_sched
    import segway_pkg::*;
#(
    parameter logic [2:0]  CH_LFT   = 3'd0,
    parameter logic [2:0]  CH_RGHT  = 3'd4,
    parameter logic [2:0]  CH_STEER = 3'd5,
    parameter logic [2:0]  CH_BATT  = 3'd6,
    parameter int unsigned GAP_CYC  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        nxt,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic        wrt,
    output logic [15:0] wt_data,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] steer_pot,
    output logic [11:0] batt,
    output logic        cnv_cmplt,
    output logic        busy
);

    localparam int unsigned GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

    rr_ch_t           r_ptr;
    logic [GAP_W-1:0] r_gap_cnt;
    logic [15:0]      r_wt_data;
    logic [11:0]      r_lft_ld;
    logic [11:0]      r_rght_ld;
    logic [11:0]      r_steer_pot;
    logic [11:0]      r_batt;

    logic [2:0]       w_ch;
    logic             w_ld_cmd;
    logic             w_ld_result;
    logic             w_clr_gap;
    logic             w_gap_en;
    logic             w_gap_tc;
    logic             w_unused_hi;

    // Upper nibble of the SPI word carries no conversion data.
    assign w_unused_hi = ^rd_data[15:12];

    a2d_sched_sm u_sm (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_nxt       (nxt),
        .i_done      (done),
        .i_gap_tc    (w_gap_tc),
        .o_wrt       (wrt),
        .o_ld_cmd    (w_ld_cmd),
        .o_ld_result (w_ld_result),
        .o_cnv_cmplt (cnv_cmplt),
        .o_clr_gap   (w_clr_gap),
        .o_gap_en    (w_gap_en),
        .o_busy      (busy)
    );

    // Map the round-robin slot to the physical A2D channel number.
    always_comb begin
        w_ch = CH_LFT;
        case (r_ptr)
            RR_LFT:   w_ch = CH_LFT;
            RR_RGHT:  w_ch = CH_RGHT;
            RR_STEER: w_ch = CH_STEER;
            RR_BATT:  w_ch = CH_BATT;
            default:  w_ch = CH_LFT;
        endcase
    end

    assign w_gap_tc = w_gap_en && (r_gap_cnt == GAP_LAST);

    // Idle-gap counter so SS_n has time to deassert between the two frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gap_cnt <= '0;
        end else if (w_clr_gap) begin
            r_gap_cnt <= '0;
        end else if (w_gap_en && !w_gap_tc) begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
        end
    end

    // Command word is captured once per conversion and reused for the read frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wt_data <= 16'h0000;
        end else if (w_ld_cmd) begin
            r_wt_data <= a2d_cmd_word(w_ch);
        end
    end

    // Round-robin pointer moves only when a conversion result is stored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= RR_LFT;
        end else if (w_ld_result) begin
            r_ptr <= rr_next(r_ptr);
        end
    end

    // Only the holding register for the current slot takes the new result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lft_ld    <= 12'h000;
            r_rght_ld   <= 12'h000;
            r_steer_pot <= 12'h000;
            r_batt      <= 12'h000;
        end else if (w_ld_result) begin
            case (r_ptr)
                RR_LFT:   r_lft_ld    <= rd_data[11:0];
                RR_RGHT:  r_rght_ld   <= rd_data[11:0];
                RR_STEER: r_steer_pot <= rd_data[11:0];
                RR_BATT:  r_batt      <= rd_data[11:0];
                default:  r_lft_ld    <= r_lft_ld;
            endcase
        end
    end

    assign wt_data   = r_wt_data;
    assign lft_ld    = r_lft_ld;
    assign rght_ld   = r_rght_ld;
    assign steer_pot = r_steer_pot;
    assign batt      = r_batt;

endmodule
